// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter and the 11011 detector bench.
package pattern_tx_pkg;

  localparam int unsigned PAT_W_DEF = 5;
  localparam logic [PAT_W_DEF-1:0] PAT_11011 = 5'b11011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pattern_tx_shreg.sv
// Parallel-load shift-left register holding the not-yet-sent pattern bits, with a bit counter.
module pattern_tx_shreg
  import pattern_tx_pkg::*;
#(
  parameter int unsigned          PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0]     PATTERN = PAT_W'(PAT_11011)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  output logic msb,
  output logic last
);

  localparam int unsigned BIT_W = $clog2(PAT_W);

  logic [PAT_W-1:0] sr_q, sr_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  // load consumes the pattern MSB immediately; msb is always the next bit to emit
  always_comb begin
    sr_d  = sr_q;
    bit_d = bit_q;
    if (load) begin
      sr_d  = {PATTERN[PAT_W-2:0], 1'b0};
      bit_d = '0;
    end else if (shift) begin
      sr_d  = {sr_q[PAT_W-2:0], 1'b0};
      bit_d = bit_q + BIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      bit_q <= '0;
    end else begin
      sr_q  <= sr_d;
      bit_q <= bit_d;
    end
  end

  assign msb  = sr_q[PAT_W-1];
  assign last = (bit_q == BIT_W'(PAT_W - 1));

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: repeated MSB-first pattern copies separated by zero gaps.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PAT_11011),
  parameter int unsigned      CNT_W   = 4,
  parameter int unsigned      GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] copies_q, copies_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift, msb, last;

  pattern_tx_shreg #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .msb   (msb),
    .last  (last)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    copies_d  = copies_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          copies_d  = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
          gap_len_d = gap;
          load      = 1'b1;
          out_d     = PATTERN[PAT_W-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          // a restart in the done cycle keeps done visible alongside busy
          done_d    = done_q;
          state_d   = SEND;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (!last) begin
          shift = 1'b1;
          out_d = msb;
        end else if (copies_q == CNT_W'(1)) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          copies_d = copies_q - CNT_W'(1);
          if (gap_len_q != '0) begin
            gap_cnt_d = gap_len_q;
            state_d   = GAP;
          end else begin
            load  = 1'b1;
            out_d = PATTERN[PAT_W-1];
          end
        end
      end
      GAP: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (gap_cnt_q == GAP_W'(1)) begin
          load    = 1'b1;
          out_d   = PATTERN[PAT_W-1];
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      copies_q  <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      copies_q  <= copies_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: expected stream bits queued at start, checked by a monitor.
module tb_pattern_tx;
  import pattern_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] repeat_n = 4'd0;
  logic [3:0] gap = 4'd0;
  logic       out, valid, busy, done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  pattern_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .repeat_n (repeat_n),
    .gap      (gap),
    .out      (out),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected stream: reps copies of 11011 MSB first, g zeros between copies
  task automatic push_stream(input int reps, input int g);
    logic [4:0] pat;
    pat = PAT_11011;
    for (int r = 0; r < reps; r++) begin
      for (int b = 4; b >= 0; b--) exp_q.push_back(pat[b]);
      if (r < reps - 1)
        for (int z = 0; z < g; z++) exp_q.push_back(1'b0);
    end
  endtask

  // Monitor: every valid cycle consumes one expected bit
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got out=%0b expected no valid bit", out);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL stream_bit: got %0b expected %0b", out, e);
        end
      end
    end
  end

  task automatic send(input int rn, input int g, input int reps);
    int n;
    int len;
    len = 5 * reps + g * (reps - 1);
    push_stream(reps, g);
    @(posedge clk); #1;
    start = 1'b1; repeat_n = 4'(rn); gap = 4'(g);
    @(posedge clk); #1;
    start = 1'b0;
    repeat_n = 4'd9; gap = 4'd7;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("len_r%0d_g%0d", rn, g), n, len);
    chk("done_pulse", int'(done), 1);
    chk("done_valid", int'(valid), 0);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_single", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    send(1, 0, 1);
    send(3, 2, 3);
    send(2, 0, 2);
    send(0, 5, 1);

    // Mid-transfer start ignored; done-cycle start accepted
    push_stream(2, 1);
    @(posedge clk); #1;
    start = 1'b1; repeat_n = 4'd2; gap = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; repeat_n = 4'd5; gap = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("mid_done_seen", int'(done), 1);
    chk("mid_done_busy", int'(busy), 0);
    chk("mid_queue", exp_q.size(), 0);
    push_stream(1, 0);
    start = 1'b1; repeat_n = 4'd1; gap = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("restart_done", int'(done), 1);
    chk("restart_busy", int'(busy), 1);
    chk("restart_valid", int'(valid), 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("restart_len", n, 5);
    chk("restart_done_end", int'(done), 1);

    // Reset during 3rd bit of copy 2 (repeat 3, gap 1)
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    @(posedge clk); #1;
    start = 1'b1; repeat_n = 4'd3; gap = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_out", int'(out), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_queue", exp_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", int'(done), 0);
      @(negedge clk);
    end
    send(1, 0, 1);

    repeat (3) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter. The stimulus-side counterpart to the 11011 non-overlapping Moore detector. On a start pulse it emits a fixed PAT_W-bit pattern MSB-first on a one-bit line, repeated a programmable number of times with a programmable run of zero gap bits between copies. It drives the detector's `in` port in system-level loopback and in regression, replacing random stimulus with known-count framed sequences.

## Interface
Parameters:
- PAT_W, 5, pattern length in bits (2..16)
- PATTERN, 5'b11011, pattern transmitted MSB (bit PAT_W-1) first
- CNT_W, 4, width of repeat count
- GAP_W, 4, width of gap length

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- repeat_n  in  CNT_W  number of pattern copies; 0 treated as 1; latched at accepted start
- gap  in  GAP_W  zero bits inserted between consecutive copies; latched at accepted start
- out  out  1  serial bit stream, registered
- valid  out  1  out carries a stream bit (pattern or gap zero)
- busy  out  1  transmission in progress; start ignored
- done  out  1  one-cycle pulse after the final pattern bit

## Operation
- FSM states: IDLE, SEND, GAP. All outputs registered (Moore).
- IDLE: out=0, valid=0, busy=0. When start=1, latch reps = max(repeat_n,1) and gap_len = gap. Load the shift register with PATTERN. Go to SEND.
- SEND: out = current MSB, valid=1, busy=1. Shift left each cycle. The bit counter runs 0..PAT_W-1.
- Leaving SEND after bit PAT_W-1:
  - Copies remain and gap_len>0: go to GAP.
  - Copies remain and gap_len=0: reload the pattern and stay in SEND, back-to-back with no bubble.
  - Last copy: go to IDLE and set done=1 for that one cycle.
- GAP: out=0, valid=1, busy=1 for exactly gap_len cycles. Then reload the pattern and go to SEND.
- Copy counter decrements once per completed copy. Counter width is CNT_W; no wrap is possible because reps ≥ 1 is the starting value.
- start while busy: ignored; no queuing.
- start in the done cycle: the FSM is in IDLE, so start is accepted. done=1 and busy=1 are then asserted together in the next cycle.
- repeat_n and gap changes while busy: no effect.
- Reset at any point, including mid-copy or mid-gap:
  - Next cycle: IDLE, out=0, valid=0, busy=0, done=0.
  - No done pulse is produced for the aborted transfer.
  - Reset overrides start in the same cycle.

## Timing
- Start accepted at edge E0. First pattern bit is visible from E0 through E1 (out valid after E0).
- Total stream length L = PAT_W·reps + gap_len·(reps−1) valid cycles, contiguous; valid never drops mid-transfer.
- busy is high for exactly those L cycles. done is high in cycle L+1 with valid=0 and busy=0.
- Minimum spacing between accepted starts is L+1 cycles.
- Reset values: out=0, valid=0, busy=0, done=0, state=IDLE.

## Structure
- Package pattern_tx_pkg holds:
  - state enum {IDLE, SEND, GAP}
  - default pattern constant PAT_11011 = 5'b11011 and PAT_W default
  - The detector bench imports the same constant.
- One sub-module is natural: pattern_tx_shreg.
  - PAT_W-bit parallel-load, shift-left register with bit counter.
  - Ports: load, shift, msb, last.
- FSM, copy counter and gap counter stay in the top.

## Test plan
- Reset, then start=1 with repeat_n=1, gap=0. Stream on out is 1,1,0,1,1 with valid high for 5 cycles. done pulses in cycle 6. Detector out asserts once.
- repeat_n=3, gap=2. Stream is 11011 00 11011 00 11011: L=19, busy high 19 cycles, done in cycle 20, detector counts 3.
- repeat_n=2, gap=0. Stream is 1101111011 with no bubble: L=10. Detector counts 2 (non-overlapping).
- repeat_n=0, gap=5. Behaves as a single copy: L=5, no gap bits emitted, done in cycle 6.
- Pulse start again mid-transfer, and in the done cycle:
  - The mid-transfer start is ignored, and the stream is unchanged.
  - The done-cycle start begins a new transfer at the next edge, with done=1 and busy=1 in the same cycle.
- Assert rst for 1 cycle during the 3rd bit of copy 2 (repeat_n=3, gap=1).
  - Next cycle: out=0, valid=0, busy=0, and no done pulse.
  - A subsequent start=1 gives a clean 11011 stream.
